// File: rtl/sumador_restador_serie.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, LSB digit first,
// with carry kept in a register between digits and flags on completion.
module sumador_restador_serie #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             Sel,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] salida,
    output logic             Co,
    output logic             V,
    output logic             Z,
    output logic             N
);

    localparam int DSAFE = (DIGIT < 1) ? 1 : DIGIT;
    localparam int STEPS = WIDTH / DSAFE;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int DW    = DIGIT + 1;

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DSAFE) != 0) begin : g_bad_params
            $fatal(1, "sumador_restador_serie: illegal WIDTH/DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh, res, res_nx;
    logic [DW-1:0]    dsum;
    logic [CW-1:0]    cnt;
    logic             carry, a_msb, b_msb, last;

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign last = (cnt == CW'(STEPS - 1));

    // One digit per cycle; the new digit enters at the top of res.
    assign dsum   = DW'(a_sh[DIGIT-1:0]) + DW'(b_sh[DIGIT-1:0]) + DW'(carry);
    assign res_nx = (res >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            carry  <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            cnt    <= '0;
            salida <= '0;
            Co     <= 1'b0;
            V      <= 1'b0;
            Z      <= 1'b0;
            N      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= A;
                        b_sh  <= B ^ {WIDTH{Sel}};
                        carry <= Sel;
                        a_msb <= A[WIDTH-1];
                        b_msb <= B[WIDTH-1] ^ Sel;
                        res   <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    carry <= dsum[DIGIT];
                    res   <= res_nx;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        salida <= res_nx;
                        Co     <= dsum[DIGIT];
                        V      <= (a_msb == b_msb) && (res_nx[WIDTH-1] != a_msb);
                        Z      <= (res_nx == '0);
                        N      <= res_nx[WIDTH-1];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sumador_restador_serie.sv
// Bench for sumador_restador_serie: three instances (DIGIT 4, 1, 16)
// driven in parallel, checked against vectors and an arithmetic model.
module tb_sumador_restador_serie;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        Sel = 1'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;

    logic        busy [3];
    logic        done [3];
    logic [15:0] sal  [3];
    logic        co   [3];
    logic        v    [3];
    logic        z    [3];
    logic        n    [3];

    int steps [3] = '{4, 16, 1};
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sumador_restador_serie #(.WIDTH(16), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start(start), .Sel(Sel), .A(A), .B(B),
        .busy(busy[0]), .done(done[0]), .salida(sal[0]),
        .Co(co[0]), .V(v[0]), .Z(z[0]), .N(n[0]));

    sumador_restador_serie #(.WIDTH(16), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start), .Sel(Sel), .A(A), .B(B),
        .busy(busy[1]), .done(done[1]), .salida(sal[1]),
        .Co(co[1]), .V(v[1]), .Z(z[1]), .N(n[1]));

    sumador_restador_serie #(.WIDTH(16), .DIGIT(16)) u_d16 (
        .clk(clk), .rst_n(rst_n), .start(start), .Sel(Sel), .A(A), .B(B),
        .busy(busy[2]), .done(done[2]), .salida(sal[2]),
        .Co(co[2]), .V(v[2]), .Z(z[2]), .N(n[2]));

    typedef struct {
        logic        s;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] es;
        logic [3:0]  ef;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string nm, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut=%0d actual=%h required=%h", nm, d, act, exp);
        end
    endtask

    // Flags packed as {Co, V, Z, N}
    function automatic logic [19:0] model(input logic s, input logic [15:0] a,
                                          input logic [15:0] b);
        logic [15:0] bb;
        logic [16:0] f;
        logic        ov;
        bb = s ? ~b : b;
        f  = {1'b0, a} + {1'b0, bb} + 17'(s);
        ov = (a[15] == bb[15]) && (f[15] != a[15]);
        return {f[16], ov, (f[15:0] == 16'h0), f[15], f[15:0]};
    endfunction

    // Caller is at a negedge; start is raised for exactly one cycle (cycle 0).
    task automatic run_op(input logic s, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] es, input logic [3:0] ef,
                          input int inj_k, input logic [15:0] inj_a);
        int          dcyc [3];
        int          dcnt [3];
        int          hbad [3];
        int          bbad [3];
        logic [15:0] prev [3];
        for (int d = 0; d < 3; d++) begin
            dcyc[d] = -1;
            dcnt[d] = 0;
            hbad[d] = 0;
            bbad[d] = 0;
            prev[d] = sal[d];
        end
        Sel = s;
        A = a;
        B = b;
        start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (done[d]) begin
                    dcnt[d]++;
                    dcyc[d] = k;
                end
                if (dcyc[d] < 0 && k <= steps[d] && sal[d] != prev[d]) hbad[d]++;
                if (busy[d] != (k <= steps[d] + 1)) bbad[d]++;
            end
            if (k == 1) begin
                start = 1'b0;
                A = ~a;
                B = ~b;
            end
            if (k == inj_k) begin
                start = 1'b1;
                A = inj_a;
            end
            if (k == inj_k + 1) start = 1'b0;
        end
        for (int d = 0; d < 3; d++) begin
            chk("done_count", d, dcnt[d], 1);
            chk("done_cycle", d, dcyc[d], steps[d] + 1);
            chk("hold_in_run", d, hbad[d], 0);
            chk("busy_window", d, bbad[d], 0);
            chk("salida", d, sal[d], es);
            chk("flags_CoVZN", d, {co[d], v[d], z[d], n[d]}, ef);
        end
    endtask

    task automatic chk_zero(input string nm);
        for (int d = 0; d < 3; d++) begin
            chk({nm, "_busy"}, d, busy[d], 0);
            chk({nm, "_done"}, d, done[d], 0);
            chk({nm, "_salida"}, d, sal[d], 0);
            chk({nm, "_flags"}, d, {co[d], v[d], z[d], n[d]}, 0);
        end
    endtask

    initial begin
        logic [19:0] m;
        logic [15:0] ra, rb;
        logic        rs;
        int          dn [3];

        vecs[0] = '{1'b1, 16'h0005, 16'h0003, 16'h0002, 4'b1000};
        vecs[1] = '{1'b1, 16'h0003, 16'h0005, 16'hFFFE, 4'b0001};
        vecs[2] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101};
        vecs[3] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010};

        repeat (2) @(negedge clk);
        chk_zero("reset_state");
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i])
            run_op(vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].es, vecs[i].ef, -1, 16'h0);

        // Second start in cycle 2 must be ignored
        run_op(1'b0, 16'h0010, 16'h0001, 16'h0011, 4'b0000, 2, 16'h1234);

        for (int i = 0; i < 20; i++) begin
            rs = 1'($urandom_range(1));
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i == 0) rb = ra;
            m = model(rs, ra, rb);
            run_op(rs, ra, rb, m[15:0], m[19:16], -1, 16'h0);
        end

        // Reset in cycle 3 abandons the operation
        Sel = 1'b0;
        A = 16'h1234;
        B = 16'h1111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        dn = '{0, 0, 0};
        repeat (20) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) if (done[d]) dn[d]++;
        end
        for (int d = 0; d < 3; d++) chk("no_done_after_abort", d, dn[d], 0);

        run_op(vecs[0].s, vecs[0].a, vecs[0].b, vecs[0].es, vecs[0].ef, -1, 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sumador_restador_serie.md
SUMADOR_RESTADOR_SERIE -- requirements
Module: sumador_restador_serie

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 4, giving the bits processed per clock cycle; STEPS = WIDTH/DIGIT.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port start, input, 1 bit: request to begin an operation.
REQ-006 Port Sel, input, 1 bit: operation select; 0 = A+B, 1 = A-B (two's complement).
REQ-007 Port A, input, WIDTH bits: first operand (addend/minuend).
REQ-008 Port B, input, WIDTH bits: second operand (addend/subtrahend).
REQ-009 Port busy, output, 1 bit: high while an operation is in progress or completing.
REQ-010 Port done, output, 1 bit: one-cycle pulse marking a new valid result.
REQ-011 Port salida, output, WIDTH bits: registered result.
REQ-012 Port Co, output, 1 bit: carry out of the MSB; for subtraction 1 = no borrow (A >= B unsigned).
REQ-013 Ports V, Z, N, output, 1 bit each: signed overflow, zero result, negative result (salida MSB).

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN, DONE; busy = (state != IDLE).
REQ-015 In IDLE with start=1 at a rising edge, the block SHALL capture A, B XOR {WIDTH{Sel}}, carry-in = Sel, clear the step counter, and enter RUN.
REQ-016 start SHALL be ignored in RUN and DONE; operand changes after capture SHALL NOT affect the result.
REQ-017 In RUN, each cycle SHALL add the next DIGIT bits, LSB digit first, propagating carry between digits via a carry register.
REQ-018 After STEPS RUN cycles the block SHALL load salida, Co, V, Z, N in the same edge and enter DONE.
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-020 Latency: with the start-sampling cycle counted as cycle 0, done SHALL be high in cycle STEPS+1 (cycle 5 at defaults); throughput is one operation per STEPS+2 cycles.
REQ-021 salida SHALL equal (A + B + 0) mod 2^WIDTH for Sel=0 and (A + ~B + 1) mod 2^WIDTH for Sel=1.
REQ-022 V SHALL be 1 iff the MSBs of A and of the inverted-or-passed B are equal and the salida MSB differs from them.
REQ-023 Z SHALL be 1 iff salida == 0; N SHALL equal salida[WIDTH-1].
REQ-024 salida, Co, V, Z, N SHALL hold their values from load until the next completion; they SHALL NOT change during RUN.
REQ-025 DIGIT = WIDTH (STEPS = 1) and DIGIT = 1 (STEPS = WIDTH) SHALL both be legal and follow identical timing rules.
REQ-026 WIDTH >= 2, DIGIT >= 1 and WIDTH mod DIGIT = 0 SHALL be enforced by an elaboration-time check that stops elaboration on violation.

Reset
REQ-027 rst_n low SHALL force, asynchronously, state = IDLE and busy, done, salida, Co, V, Z, N, and all internal registers to 0.
REQ-028 Reset asserted during RUN or DONE SHALL abandon the operation: no done pulse, no output update.
REQ-029 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification (WIDTH=16, DIGIT=4)
REQ-030 Sel=1, A=0x0005, B=0x0003, start pulse -> done in cycle 5, salida=0x0002, Co=1, V=0, Z=0, N=0.
REQ-031 Sel=1, A=0x0003, B=0x0005 -> salida=0xFFFE, Co=0, V=0, Z=0, N=1.
REQ-032 Sel=0, A=0x7FFF, B=0x0001 -> salida=0x8000, Co=0, V=1, N=1; then Sel=0, A=0xFFFF, B=0x0001 -> salida=0x0000, Co=1, V=0, Z=1.
REQ-033 start with A=0x0010, B=0x0001, Sel=0, then start with A=0x1234 in cycle 2 -> second request ignored, single done, salida=0x0011, busy high cycles 1-5.
REQ-034 rst_n low in cycle 3 of an operation -> busy=0 and all outputs 0 immediately, no done pulse; new start after release completes in 5 cycles.
REQ-035 Repeat REQ-030..REQ-032 with DIGIT=1 and DIGIT=16 -> identical results, done in cycles 17 and 2 respectively.
